// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 7-segment scan controller with blanking, sign, dead time and frame-synchronous updates
module disp_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb_en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    neg_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t                  state, n_state;
  logic [IW-1:0]           idx, n_idx;
  logic [CW-1:0]           cnt, n_cnt;
  logic [4*NUM_DIGITS-1:0] act, n_act, pend;
  logic                    neg, n_neg, pend_neg, pend_full, n_full, wrap, swap;
  // The MSD reads as zero under a minus sign, so a negative number blanks right down to its top significant digit.
  function automatic logic [3:0] code(input logic [IW-1:0] i, input logic [4*NUM_DIGITS-1:0] d,
                                      input logic ng, input logic lz);
    logic z;
    z = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(i)) z = z & ((d[4*k+:4] == 4'd0) || (k == NUM_DIGITS - 1 && ng));
    code = (int'(i) == NUM_DIGITS - 1 && ng) ? 4'hF : (lz && i != '0 && z) ? 4'hE : d[4*int'(i)+:4];
  endfunction
  // Next-state for the scan sequencer and the pending/active double buffer.
  always_comb begin
    n_state = state;
    n_idx   = idx;
    n_cnt   = cnt;
    n_act   = act;
    n_neg   = neg;
    n_full  = pend_full;
    wrap    = 1'b0;
    if (!enable) begin
      n_state = IDLE;
      n_idx   = '0;
      n_cnt   = '0;
    end else if (state == IDLE) begin
      n_state = BLANK;
      n_idx   = '0;
      n_cnt   = '0;
    end else if (cnt == SLOT_LAST) begin
      n_state = BLANK;
      n_cnt   = '0;
      wrap    = idx == IDX_LAST;
      n_idx   = wrap ? '0 : idx + 1'b1;
    end else begin
      n_cnt   = cnt + 1'b1;
      n_state = (cnt == BLANK_LAST) ? SHOW : state;
    end
    swap = pend_full && (state == IDLE || wrap);
    if (swap) begin
      n_act  = pend;
      n_neg  = pend_neg;
      n_full = 1'b0;
    end
    if (upd_valid && upd_ready) n_full = 1'b1;
  end
  // State and outputs are registered together, outputs derived from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      act        <= '0;
      neg        <= 1'b0;
      pend       <= '0;
      pend_neg   <= 1'b0;
      pend_full  <= 1'b0;
      upd_ready  <= 1'b1;
      bcd_out    <= 4'hE;
      dig_en_n   <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= n_state;
      idx        <= n_idx;
      cnt        <= n_cnt;
      act        <= n_act;
      neg        <= n_neg;
      pend_full  <= n_full;
      if (upd_valid && upd_ready) begin
        pend     <= digits_in;
        pend_neg <= neg_in;
      end
      upd_ready  <= ~n_full;
      bcd_out    <= (n_state == IDLE) ? 4'hE : code(n_idx, n_act, n_neg, lzb_en);
      dig_en_n   <= (n_state == SHOW) ? ~(NUM_DIGITS'(1) << n_idx) : '1;
      frame_done <= wrap;
    end
  end
endmodule
